// File: rtl/sort_addr_ctrl.sv
// Control FSM for an in-place selection sort: walks outer index i and inner index j
// over the element RAM, tracks the running minimum and swaps A[i] with A[min] per pass.
`timescale 1ns/1ps

module sort_addr_ctrl #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_len,
    input  logic [SIZE_DATA-1:0] i_rdata,
    output logic                 o_rd_en,
    output logic                 o_wr_en,
    output logic [1:0]           o_sel_addr,
    output logic [SIZE_ADDR-1:0] o_value_i,
    output logic [SIZE_ADDR-1:0] o_value_j,
    output logic [SIZE_ADDR-1:0] o_value_min,
    output logic [SIZE_DATA-1:0] o_wdata,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [3:0] {
        IDLE, RD_I, CAP_I, RD_J, CMP_J, WR_MIN, WR_I, NEXT_I, DONE
    } state_t;

    state_t               state, state_nxt;
    logic [SIZE_ADDR-1:0] len, len_nxt;
    logic [SIZE_ADDR-1:0] idx_i, idx_i_nxt;
    logic [SIZE_ADDR-1:0] idx_j, idx_j_nxt;
    logic [SIZE_ADDR-1:0] idx_min, idx_min_nxt;
    logic [SIZE_DATA-1:0] val_i, val_i_nxt;
    logic [SIZE_DATA-1:0] min_val, min_val_nxt;
    logic                 rdata_less;
    logic [SIZE_ADDR-1:0] min_cand;

    assign o_value_i   = idx_i;
    assign o_value_j   = idx_j;
    assign o_value_min = idx_min;

    // Strict compare so that ties keep the earlier index
    assign rdata_less = (i_rdata < min_val);
    assign min_cand   = rdata_less ? idx_j : idx_min;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            len     <= '0;
            idx_i   <= '0;
            idx_j   <= '0;
            idx_min <= '0;
            val_i   <= '0;
            min_val <= '0;
        end else begin
            state   <= state_nxt;
            len     <= len_nxt;
            idx_i   <= idx_i_nxt;
            idx_j   <= idx_j_nxt;
            idx_min <= idx_min_nxt;
            val_i   <= val_i_nxt;
            min_val <= min_val_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        idx_i_nxt   = idx_i;
        idx_j_nxt   = idx_j;
        idx_min_nxt = idx_min;
        val_i_nxt   = val_i;
        min_val_nxt = min_val;
        o_rd_en     = 1'b0;
        o_wr_en     = 1'b0;
        o_sel_addr  = 2'b00;
        o_wdata     = '0;
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);

        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_len > SIZE_ADDR'(1)) begin
                        len_nxt   = i_len;
                        idx_i_nxt = '0;
                        state_nxt = RD_I;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RD_I: begin
                o_sel_addr = 2'b11;
                o_rd_en    = 1'b1;
                state_nxt  = CAP_I;
            end
            CAP_I: begin
                val_i_nxt   = i_rdata;
                min_val_nxt = i_rdata;
                idx_min_nxt = idx_i;
                idx_j_nxt   = idx_i + 1'b1;
                state_nxt   = RD_J;
            end
            RD_J: begin
                o_sel_addr = 2'b10;
                o_rd_en    = 1'b1;
                state_nxt  = CMP_J;
            end
            CMP_J: begin
                if (rdata_less) begin
                    idx_min_nxt = idx_j;
                    min_val_nxt = i_rdata;
                end
                // The swap decision must use the minimum including this compare
                if (idx_j == len - 1'b1) begin
                    state_nxt = (min_cand != idx_i) ? WR_MIN : NEXT_I;
                end else begin
                    idx_j_nxt = idx_j + 1'b1;
                    state_nxt = RD_J;
                end
            end
            WR_MIN: begin
                o_sel_addr = 2'b01;
                o_wr_en    = 1'b1;
                o_wdata    = val_i;
                state_nxt  = WR_I;
            end
            WR_I: begin
                o_sel_addr = 2'b11;
                o_wr_en    = 1'b1;
                o_wdata    = min_val;
                state_nxt  = NEXT_I;
            end
            NEXT_I: begin
                if (idx_i == len - 2'd2) begin
                    state_nxt = DONE;
                end else begin
                    idx_i_nxt = idx_i + 1'b1;
                    state_nxt = RD_I;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sort_addr_ctrl.sv
// Bench for sort_addr_ctrl: a small RAM with address mux around the DUT, a plain
// selection-sort reference model, directed cases plus randomized arrays.
`timescale 1ns/1ps

module tb_sort_addr_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_len = '0;
    logic [7:0] i_rdata;
    logic       o_rd_en, o_wr_en, o_busy, o_done;
    logic [1:0] o_sel_addr;
    logic [7:0] o_value_i, o_value_j, o_value_min, o_wdata;

    sort_addr_ctrl #(.SIZE_ADDR(8), .SIZE_DATA(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
        .i_rdata(i_rdata), .o_rd_en(o_rd_en), .o_wr_en(o_wr_en),
        .o_sel_addr(o_sel_addr), .o_value_i(o_value_i), .o_value_j(o_value_j),
        .o_value_min(o_value_min), .o_wdata(o_wdata), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0]  mem [0:255];
    logic [7:0]  ram_addr, held_addr = '0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0, load_data = '0;
    int          rd_count = 0, wr_count = 0, done_count = 0, busy_count = 0;
    logic [15:0] wr_log [$];

    logic [7:0]  stim [0:255];
    int          model_arr [0:255];
    logic [15:0] exp_wr [$];
    int          exp_cycles;
    int          total_checks = 0, passed_checks = 0, failed_checks = 0;

    // Address select mux with hold, as the downstream RAM address block would see it
    always_comb begin
        case (o_sel_addr)
            2'b11:   ram_addr = o_value_i;
            2'b10:   ram_addr = o_value_j;
            2'b01:   ram_addr = o_value_min;
            default: ram_addr = held_addr;
        endcase
    end

    always @(posedge i_clk) begin
        held_addr <= ram_addr;
        if (load_en)
            mem[load_addr] <= load_data;
        else if (o_wr_en)
            mem[ram_addr] <= o_wdata;
        if (o_rd_en)
            i_rdata <= mem[ram_addr];
    end

    always @(negedge i_clk) begin
        if (o_rd_en) rd_count <= rd_count + 1;
        if (o_done)  done_count <= done_count + 1;
        if (o_busy)  busy_count <= busy_count + 1;
        if (o_wr_en) begin
            wr_count <= wr_count + 1;
            wr_log.push_back({ram_addr, o_wdata});
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, ":rd_en"}, 32'(o_rd_en), 0);
        check_output({tag, ":wr_en"}, 32'(o_wr_en), 0);
        check_output({tag, ":sel"}, 32'(o_sel_addr), 0);
        check_output({tag, ":idx"}, {8'h0, o_value_i, o_value_j, o_value_min}, 0);
        check_output({tag, ":wdata"}, 32'(o_wdata), 0);
        check_output({tag, ":busy_done"}, {30'h0, o_busy, o_done}, 0);
    endtask

    task automatic load_ram(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            load_en   = 1'b1;
            load_addr = 8'(k);
            load_data = stim[k];
        end
        @(negedge i_clk);
        load_en = 1'b0;
    endtask

    // Plain selection sort over the stimulus, recording the expected write pairs
    task automatic build_model(input int n);
        int swaps;
        int m;
        int tmp;
        swaps = 0;
        exp_wr.delete();
        for (int k = 0; k < 256; k++) model_arr[k] = int'(stim[k]);
        for (int p = 0; p < n - 1; p++) begin
            m = p;
            for (int q = p + 1; q < n; q++)
                if (model_arr[q] < model_arr[m]) m = q;
            if (m != p) begin
                exp_wr.push_back({8'(m), 8'(model_arr[p])});
                exp_wr.push_back({8'(p), 8'(model_arr[m])});
                tmp = model_arr[p];
                model_arr[p] = model_arr[m];
                model_arr[m] = tmp;
                swaps++;
            end
        end
        exp_cycles = (n < 2) ? 1 : (n - 1) * (n + 3) + 2 * swaps + 1;
    endtask

    task automatic apply_stimulus(input int n, input int mid_start, input string tag);
        int rd0, wr0, done0, log0, cycles;
        load_ram(n);
        build_model(n);
        rd0 = rd_count; wr0 = wr_count; done0 = done_count; log0 = wr_log.size();
        @(negedge i_clk);
        i_len   = 8'(n);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_len   = 8'($urandom_range(0, 255));
        cycles  = 1;
        while (o_done !== 1'b1 && cycles < 4000) begin
            if (cycles == mid_start) i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
            cycles++;
        end
        check_output({tag, ":done_seen"}, 32'(o_done), 1);
        check_output({tag, ":cycles"}, 32'(cycles), 32'(exp_cycles));
        check_output({tag, ":busy_at_done"}, 32'(o_busy), 1);
        repeat (4) @(negedge i_clk);
        check_output({tag, ":done_pulses"}, 32'(done_count - done0), 1);
        check_output({tag, ":busy_after"}, 32'(o_busy), 0);
        if (n < 2) check_output({tag, ":reads"}, 32'(rd_count - rd0), 0);
        check_output({tag, ":writes"}, 32'(wr_count - wr0), 32'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size(); k++)
            if (log0 + k < wr_log.size())
                check_output({tag, ":wr_pair"}, 32'(wr_log[log0 + k]), 32'(exp_wr[k]));
        for (int k = 0; k < n; k++)
            check_output({tag, ":ram"}, 32'(mem[k]), 32'(model_arr[k]));
    endtask

    initial begin
        int n, rd0, wr0, busy0;

        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        {stim[0], stim[1], stim[2], stim[3]} = {8'd3, 8'd1, 8'd2, 8'd0};
        apply_stimulus(4, 0, "basic4");

        {stim[0], stim[1], stim[2], stim[3], stim[4]} = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        apply_stimulus(5, 0, "sorted5");

        {stim[0], stim[1], stim[2], stim[3]} = {8'd2, 8'd2, 8'd1, 8'd1};
        apply_stimulus(4, 0, "dups4");

        apply_stimulus(0, 0, "len0");
        apply_stimulus(1, 0, "len1");

        {stim[0], stim[1], stim[2]} = {8'hFF, 8'h00, 8'h80};
        apply_stimulus(3, 5, "extreme3");

        // Reset in the middle of a sort, then a quiet period, then a normal run
        {stim[0], stim[1], stim[2], stim[3]} = {8'd3, 8'd1, 8'd2, 8'd0};
        load_ram(4);
        @(negedge i_clk);
        i_len = 8'd4;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (8) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rd0 = rd_count; wr0 = wr_count; busy0 = busy_count;
        repeat (10) @(negedge i_clk);
        check_output("quiet:busy", 32'(busy_count - busy0), 0);
        check_output("quiet:enables", 32'((rd_count - rd0) + (wr_count - wr0)), 0);
        {stim[0], stim[1], stim[2], stim[3]} = {8'd3, 8'd1, 8'd2, 8'd0};
        apply_stimulus(4, 0, "after_reset");

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(2, 12);
            for (int k = 0; k < n; k++)
                stim[k] = (r % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            apply_stimulus(n, (r % 3 == 0) ? $urandom_range(1, 10) : 0, $sformatf("rand%0d", r));
        end

        $display("[TB] run complete");
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
